// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 message padder: FSM encoding, padding
// constants and a byte-lane insertion helper.
package sha256_pkg;

    typedef enum logic [2:0] {
        DATA   = 3'd0,
        PAD    = 3'd1,
        ZERO   = 3'd2,
        LEN_HI = 3'd3,
        LEN_LO = 3'd4
    } pad_state_t;

    localparam logic [7:0]       PAD_BYTE      = 8'h80;
    localparam int               WORDS_PER_BLK = 16;
    localparam int               IDX_W         = $clog2(WORDS_PER_BLK);
    localparam logic [IDX_W-1:0] LEN_HI_IDX    = IDX_W'(14);
    // Last index at which zero fill may still be emitted before the length
    localparam logic [IDX_W-1:0] ZERO_END_IDX  = LEN_HI_IDX - IDX_W'(1);
    localparam logic [IDX_W-1:0] LAST_IDX      = IDX_W'(WORDS_PER_BLK - 1);

    // Write byte b into big-endian lane 'lane' of word w (lane 0 = bits 31:24)
    function automatic logic [31:0] put_byte(input logic [31:0] w,
                                             input logic [1:0]  lane,
                                             input logic [7:0]  b);
        logic [31:0] r;
        r = w;
        case (lane)
            2'd0:    r[31:24] = b;
            2'd1:    r[23:16] = b;
            2'd2:    r[15:8]  = b;
            default: r[7:0]   = b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sha256_padder.sv
// SHA-256 message padder. Packs an incoming byte stream into big-endian
// 32-bit words, appends the 0x80 marker, zero fill and the 64-bit message
// bit length, and hands 16-word blocks to a downstream hash core over a
// valid/ready interface with a one-deep registered output.
module sha256_padder
    import sha256_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_blk_last,
    output logic             out_msg_last,
    output logic             busy
);

    pad_state_t       r_state;
    logic [31:0]      r_word;      // partially packed word, unused lanes zero
    logic [1:0]       r_lane;      // next byte lane to fill
    logic [IDX_W-1:0] r_idx;       // index the next emitted word will carry
    logic [LEN_W-1:0] r_cnt;       // accepted byte count for this message
    logic             r_rst_done;  // low until the first edge after reset

    logic             w_out_free;
    logic             w_accept;
    logic [31:0]      w_word_in;
    logic [31:0]      w_word_pad;
    logic [LEN_W-1:0] w_len;
    pad_state_t       w_fill_state;
    logic             w_emit;
    logic [31:0]      w_emit_data;
    logic             w_emit_msg_last;

    // The output register can take a new word when empty or being drained
    assign w_out_free = !out_valid || out_ready;
    assign in_ready   = r_rst_done && (r_state == DATA) && w_out_free;
    assign w_accept   = in_valid && in_ready;

    // Current word with the incoming byte placed in its lane
    assign w_word_in  = put_byte(r_word, r_lane, in_data);
    // Final partial word: marker goes in the lane after the last byte; a
    // full final word carries no marker (it follows as a separate word)
    assign w_word_pad = (r_lane == 2'd3) ? w_word_in
                                         : put_byte(w_word_in, r_lane + 2'd1, PAD_BYTE);

    // Bit length is the byte count times eight, wrapping modulo 2^LEN_W
    assign w_len = {r_cnt[LEN_W-4:0], 3'b000};

    // After emitting the word at r_idx, the length goes out once index 14
    // is next; otherwise zero fill continues (possibly into a new block)
    assign w_fill_state = (r_idx == ZERO_END_IDX) ? LEN_HI : ZERO;

    // Choose the word, if any, that is loaded into the output register
    always_comb begin
        w_emit          = 1'b0;
        w_emit_data     = '0;
        w_emit_msg_last = 1'b0;
        case (r_state)
            DATA: begin
                if (w_accept && in_last) begin
                    w_emit      = 1'b1;
                    w_emit_data = w_word_pad;
                end else if (w_accept && (r_lane == 2'd3)) begin
                    w_emit      = 1'b1;
                    w_emit_data = w_word_in;
                end
            end
            PAD: begin
                w_emit      = w_out_free;
                w_emit_data = {PAD_BYTE, 24'h000000};
            end
            ZERO: begin
                w_emit      = w_out_free;
                w_emit_data = '0;
            end
            LEN_HI: begin
                w_emit      = w_out_free;
                w_emit_data = w_len[63:32];
            end
            LEN_LO: begin
                w_emit          = w_out_free;
                w_emit_data     = w_len[31:0];
                w_emit_msg_last = 1'b1;
            end
            default: begin
                w_emit = 1'b0;
            end
        endcase
    end

    // Padding FSM with inline byte packer, byte counter and output register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state      <= DATA;
            r_word       <= '0;
            r_lane       <= '0;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_rst_done   <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_idx      <= '0;
            out_blk_last <= 1'b0;
            out_msg_last <= 1'b0;
            busy         <= 1'b0;
        end else begin
            r_rst_done <= 1'b1;

            // Byte packing and counting
            if (w_accept) begin
                r_cnt <= r_cnt + LEN_W'(1);
                if (in_last || (r_lane == 2'd3)) begin
                    r_word <= '0;
                    r_lane <= '0;
                end else begin
                    r_word <= w_word_in;
                    r_lane <= r_lane + 2'd1;
                end
            end

            // State transitions
            case (r_state)
                DATA: begin
                    if (w_accept && in_last)
                        r_state <= (r_lane == 2'd3) ? PAD : w_fill_state;
                end
                PAD, ZERO: begin
                    if (w_out_free)
                        r_state <= w_fill_state;
                end
                LEN_HI: begin
                    if (w_out_free)
                        r_state <= LEN_LO;
                end
                LEN_LO: begin
                    if (w_out_free) begin
                        r_state <= DATA;
                        r_cnt   <= '0;
                    end
                end
                default: r_state <= DATA;
            endcase

            // Output register: retire on handshake, reload on emit
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (w_emit) begin
                out_valid    <= 1'b1;
                out_data     <= w_emit_data;
                out_idx      <= r_idx;
                out_blk_last <= (r_idx == LAST_IDX);
                out_msg_last <= w_emit_msg_last;
                r_idx        <= r_idx + IDX_W'(1);
            end

            // Busy spans first accepted byte to acceptance of the last word
            if (w_accept)
                busy <= 1'b1;
            else if (out_valid && out_ready && out_msg_last)
                busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sha256_padder.sv
// Bench for sha256_padder: directed messages, expected words queued at
// stimulus time and compared by an independent output monitor.
module tb_sha256_padder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_idx;
    logic        out_blk_last;
    logic        out_msg_last;
    logic        busy;

    sha256_padder #(.LEN_W(64)) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_idx      (out_idx),
        .out_blk_last (out_blk_last),
        .out_msg_last (out_msg_last),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  idx;
        logic        bl;
        logic        ml;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   blk_pulses = 0;
    logic rand_ready = 1'b0;
    logic stall = 1'b0;

    logic        hold_v = 1'b0;
    logic [31:0] hold_d;
    logic [3:0]  hold_i;
    logic        hold_bl;
    logic        hold_ml;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [31:0] d, input int idx, input logic ml);
        exp_t e;
        e.d   = d;
        e.idx = 4'(idx);
        e.bl  = (idx == 15);
        e.ml  = ml;
        sb.push_back(e);
    endtask

    // Hand-written words for "abc"
    task automatic push_abc();
        push_exp(32'h61626380, 0, 1'b0);
        for (int i = 1; i <= 14; i++) push_exp(32'h0, i, 1'b0);
        push_exp(32'h00000018, 15, 1'b1);
    endtask

    // Reference padding: byte-level SHA-256 padding, then grouped into words
    task automatic push_model(input string s);
        byte unsigned     b[$];
        longint unsigned  bits;
        int               nw;
        bits = 64'(s.len()) * 64'd8;
        for (int i = 0; i < s.len(); i++) b.push_back(s[i]);
        b.push_back(8'h80);
        while ((b.size() % 64) != 56) b.push_back(8'h00);
        for (int k = 7; k >= 0; k--) b.push_back(8'(bits >> (8 * k)));
        nw = b.size() / 4;
        for (int w = 0; w < nw; w++)
            push_exp({b[4*w], b[4*w+1], b[4*w+2], b[4*w+3]}, w % 16, w == nw - 1);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && n < 500) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: in_ready=%0b, required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], i == s.len() - 1);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy || out_valid) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_queue_empty"}, 64'(sb.size()), 64'd0);
        check({name, "_busy_clear"}, 64'(busy), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Downstream ready: held low when stalling, random or always high otherwise
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            out_ready = stall ? 1'b0 : (rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
        end
    end

    // Monitor: compare each accepted word against the scoreboard and check
    // that a stalled word is held unchanged
    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_data", 64'(out_data), 64'(hold_d));
                check("stall_idx", 64'(out_idx), 64'(hold_i));
                check("stall_flags", 64'({out_blk_last, out_msg_last}), 64'({hold_bl, hold_ml}));
            end
            hold_v = 1'b0;
            if (out_valid && !out_ready) begin
                hold_v  = 1'b1;
                hold_d  = out_data;
                hold_i  = out_idx;
                hold_bl = out_blk_last;
                hold_ml = out_msg_last;
                check("stall_in_ready", 64'(in_ready), 64'd0);
            end
            if (out_valid && out_ready) begin
                if (out_blk_last) blk_pulses++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %08h idx %0d, required no word", out_data, out_idx);
                end else begin
                    mon_e = sb.pop_front();
                    check($sformatf("word_data[%0d]", mon_e.idx), 64'(out_data), 64'(mon_e.d));
                    check($sformatf("word_idx[%0d]", mon_e.idx), 64'(out_idx), 64'(mon_e.idx));
                    check($sformatf("word_blk_last[%0d]", mon_e.idx), 64'(out_blk_last), 64'(mon_e.bl));
                    check($sformatf("word_msg_last[%0d]", mon_e.idx), 64'(out_msg_last), 64'(mon_e.ml));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_idx", 64'(out_idx), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // "abc"
        push_abc();
        send_str("abc");
        check("abc_busy", 64'(busy), 64'd1);
        wait_drain("abc");

        // 55-byte message, one block
        push_model("4hp94ZfeUXMYICVGin77QuWsZNgaCJVRVlwnRxg4S4RC7dO5be73iUl");
        send_str("4hp94ZfeUXMYICVGin77QuWsZNgaCJVRVlwnRxg4S4RC7dO5be73iUl");
        wait_drain("msg55");

        // 56 bytes of 'A': marker at idx 14, length in a second block
        for (int i = 0; i < 14; i++) push_exp(32'h41414141, i, 1'b0);
        push_exp(32'h80000000, 14, 1'b0);
        push_exp(32'h00000000, 15, 1'b0);
        for (int i = 0; i < 15; i++) push_exp(32'h0, i, 1'b0);
        push_exp(32'h000001C0, 15, 1'b1);
        for (int i = 0; i < 56; i++) begin
            send_byte(8'h41, i == 55);
            if (i == 3) begin
                check("latency_valid", 64'(out_valid), 64'd1);
                check("latency_data", 64'(out_data), 64'h41414141);
            end
        end
        wait_drain("msg56");

        // 64 bytes of 'A': marker word opens block 2
        blk_pulses = 0;
        for (int i = 0; i < 16; i++) push_exp(32'h41414141, i, 1'b0);
        push_exp(32'h80000000, 0, 1'b0);
        for (int i = 1; i < 15; i++) push_exp(32'h0, i, 1'b0);
        push_exp(32'h00000200, 15, 1'b1);
        for (int i = 0; i < 64; i++) send_byte(8'h41, i == 63);
        wait_drain("msg64");
        check("msg64_blk_last_pulses", 64'(blk_pulses), 64'd2);

        // "abc" under random downstream back-pressure
        rand_ready = 1'b1;
        push_abc();
        send_str("abc");
        wait_drain("abc_rand");
        rand_ready = 1'b0;

        // Reset while a word is held in the output register
        stall = 1'b1;
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("stalled_valid", 64'(out_valid), 64'd1);
        check("stalled_in_ready", 64'(in_ready), 64'd0);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_data", 64'(out_data), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        stall = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset after 10 bytes, then "abc" must come out unaffected
        push_exp(32'h42424242, 0, 1'b0);
        push_exp(32'h42424242, 1, 1'b0);
        for (int i = 0; i < 10; i++) send_byte(8'h42, 1'b0);
        for (int n = 0; n < 50 && sb.size() != 0; n++) @(posedge clk);
        check("partial_words_seen", 64'(sb.size()), 64'd0);
        check("partial_busy", 64'(busy), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst10_out_valid", 64'(out_valid), 64'd0);
        check("rst10_out_idx", 64'(out_idx), 64'd0);
        check("rst10_busy", 64'(busy), 64'd0);
        check("rst10_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst10_release_in_ready", 64'(in_ready), 64'd1);
        push_abc();
        send_str("abc");
        wait_drain("abc_after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
